// File: rtl/seq_det_prog.sv
// -----------------------------------------------------------------------------
// seq_det_prog
//
// Runtime-programmable serial sequence detector. It watches a valid-qualified
// serial bit stream and pulses 'out' for one cycle whenever the most recent
// 'len' accepted bits equal the active pattern, ignoring don't-care positions.
// The pattern, mask, length and overlap mode are loaded at run time, so no
// re-synthesis is needed. A saturating match counter is provided.
//
// Bit ordering: pattern/mask bit 0 corresponds to the most recently accepted
// bit, bit 1 to the bit before it, and so on.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high; restores the default config
//   data_valid   in   qualifies data_stream
//   data_stream  in   serial input bit
//   cfg_load     in   one-cycle strobe; latches cfg_* and clears history/count
//   cfg_pattern  in   [N_MAX-1:0] pattern to match
//   cfg_mask     in   [N_MAX-1:0] 1 = compare bit, 0 = don't care
//   cfg_len      in   [LW-1:0] pattern length (0 -> 1, >N_MAX -> N_MAX)
//   cfg_overlap  in   1 = overlapping matches allowed
//   out          out  registered one-cycle match pulse
//   match_count  out  [CW-1:0] saturating match counter
//   count_sat    out  sticky: counter has reached all-ones
//   armed        out  registered: fill >= active length
// -----------------------------------------------------------------------------
module seq_det_prog #(
  parameter int                N_MAX           = 8,
  parameter int                CW              = 8,
  parameter int                DEFAULT_LEN     = 4,
  parameter logic [N_MAX-1:0]  DEFAULT_PATTERN = 8'b0000_0110,
  localparam int               LW              = $clog2(N_MAX + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_valid,
  input  logic             data_stream,
  input  logic             cfg_load,
  input  logic [N_MAX-1:0] cfg_pattern,
  input  logic [N_MAX-1:0] cfg_mask,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  output logic             out,
  output logic [CW-1:0]    match_count,
  output logic             count_sat,
  output logic             armed
);

  localparam logic [LW-1:0] LEN_MAX = LW'(N_MAX);
  localparam logic [LW-1:0] LEN_DEF = LW'(DEFAULT_LEN);
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Zero length is meaningless (would match every bit with no compare), so it
  // is promoted to 1; lengths beyond the shift register are clipped.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    logic [LW-1:0] r;
    if (l == '0) begin
      r = LW'(1);
    end else if (l > LEN_MAX) begin
      r = LEN_MAX;
    end else begin
      r = l;
    end
    return r;
  endfunction

  // Mask with the low l bits set: restricts the compare to the active length.
  function automatic logic [N_MAX-1:0] len_to_mask(input logic [LW-1:0] l);
    logic [N_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < N_MAX; i++) begin
      m[i] = (i < int'(l));
    end
    return m;
  endfunction

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    if (c == CNT_MAX) begin
      r = c;
    end else begin
      r = c + CW'(1);
    end
    return r;
  endfunction

  // Active configuration
  logic [N_MAX-1:0] pattern_q;
  logic [N_MAX-1:0] mask_q;
  logic [LW-1:0]    len_q;
  logic             overlap_q;

  // Stream state
  logic [N_MAX-1:0] shift_p1;
  logic [LW-1:0]    fill_p1;
  logic             match_p1;
  logic [CW-1:0]    count_p1;
  logic             sat_p1;
  logic             armed_p1;

  // Combinational evaluation of the incoming bit
  logic [N_MAX-1:0] shift_next;
  logic [N_MAX-1:0] len_mask;
  logic [N_MAX-1:0] diff;
  logic [LW:0]      fill_inc;
  logic             len_ok;
  logic             hit;
  logic [LW-1:0]    fill_acc;
  logic [LW-1:0]    fill_next;
  logic [CW-1:0]    count_next;

  always_comb begin
    shift_next = {shift_p1[N_MAX-2:0], data_stream};
    len_mask   = len_to_mask(len_q);
    // Compare against the history including the bit arriving now, so the
    // registered pulse lands on the same edge that samples the final bit.
    diff       = (shift_next ^ pattern_q) & mask_q & len_mask;
    fill_inc   = {1'b0, fill_p1} + (LW+1)'(1);
    len_ok     = (fill_inc >= {1'b0, len_q});
    hit        = data_valid && len_ok && (diff == '0);

    if (fill_p1 == LEN_MAX) begin
      fill_acc = fill_p1;
    end else begin
      fill_acc = fill_p1 + LW'(1);
    end

    // Non-overlapping: a match consumes the history, so a fresh len bits
    // are needed before the next match. Shift contents are left as-is.
    if (hit && !overlap_q) begin
      fill_next = '0;
    end else begin
      fill_next = fill_acc;
    end

    count_next = sat_inc(count_p1);
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_q <= DEFAULT_PATTERN;
      mask_q    <= '1;
      len_q     <= clamp_len(LEN_DEF);
      overlap_q <= 1'b1;
      shift_p1  <= '0;
      fill_p1   <= '0;
      match_p1  <= 1'b0;
      count_p1  <= '0;
      sat_p1    <= 1'b0;
      armed_p1  <= 1'b0;
    end else if (cfg_load) begin
      // Any data bit in this cycle is dropped: history restarts with the
      // new configuration.
      pattern_q <= cfg_pattern;
      mask_q    <= cfg_mask;
      len_q     <= clamp_len(cfg_len);
      overlap_q <= cfg_overlap;
      shift_p1  <= '0;
      fill_p1   <= '0;
      match_p1  <= 1'b0;
      count_p1  <= '0;
      sat_p1    <= 1'b0;
      armed_p1  <= 1'b0;
    end else begin
      match_p1 <= hit;
      if (data_valid) begin
        shift_p1 <= shift_next;
        fill_p1  <= fill_next;
        armed_p1 <= (fill_next >= len_q);
      end
      if (hit) begin
        count_p1 <= count_next;
        if (count_next == CNT_MAX) begin
          sat_p1 <= 1'b1;
        end
      end
    end
  end

  assign out         = match_p1;
  assign match_count = count_p1;
  assign count_sat   = sat_p1;
  assign armed       = armed_p1;

endmodule

// File: tb/tb_seq_det_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_det_prog
//
// Directed self-checking bench for seq_det_prog. Two instances share the same
// stimulus: the default one (CW=8) and a narrow-counter one (CW=3) used for
// the saturation scenario.
// -----------------------------------------------------------------------------
module tb_seq_det_prog;

  logic       clock;
  logic       reset;
  logic       data_valid;
  logic       data_stream;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [7:0] cfg_mask;
  logic [3:0] cfg_len;
  logic       cfg_overlap;

  logic       out;
  logic [7:0] match_count;
  logic       count_sat;
  logic       armed;

  logic       out3;
  logic [2:0] match_count3;
  logic       count_sat3;
  logic       armed3;

  int checks;
  int failures;

  seq_det_prog dut (
    .clock       (clock),
    .reset       (reset),
    .data_valid  (data_valid),
    .data_stream (data_stream),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out),
    .match_count (match_count),
    .count_sat   (count_sat),
    .armed       (armed)
  );

  seq_det_prog #(.CW(3)) u_sat (
    .clock       (clock),
    .reset       (reset),
    .data_valid  (data_valid),
    .data_stream (data_stream),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out3),
    .match_count (match_count3),
    .count_sat   (count_sat3),
    .armed       (armed3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock with the given data inputs; returns 1 time unit after the edge.
  task automatic drive(input logic v, input logic d);
    data_valid  = v;
    data_stream = d;
    cfg_load    = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [7:0] msk,
                          input logic [3:0] len, input logic ov,
                          input logic v, input logic d);
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    data_valid  = v;
    data_stream = d;
    @(posedge clock);
    #1;
    cfg_load   = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    data_valid = 1'b0;
    cfg_load   = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_valid = 1'b1;
    data_stream = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    data_valid = 1'b0;
    checks++;
    if (out !== 1'b0) begin
      failures++; $display("FAIL reset_out actual=%b expected=0", out);
    end
    checks++;
    if (match_count !== 8'd0) begin
      failures++; $display("FAIL reset_count actual=%0d expected=0", match_count);
    end
    checks++;
    if (count_sat !== 1'b0) begin
      failures++; $display("FAIL reset_sat actual=%b expected=0", count_sat);
    end
    checks++;
    if (armed !== 1'b0) begin
      failures++; $display("FAIL reset_armed actual=%b expected=0", armed);
    end
  endtask

  // Default pattern 0110, len 4, overlapping: 0110110 -> pulses on bits 4, 7.
  task automatic test_defaults();
    logic [6:0] s;
    logic [6:0] exp_out;
    s       = 7'b0110110;
    exp_out = 7'b0001001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s[6-i]);
      checks++;
      if (out !== exp_out[6-i]) begin
        failures++; $display("FAIL defaults_out bit=%0d actual=%b expected=%b", i+1, out, exp_out[6-i]);
      end
      checks++;
      if (armed !== (i >= 3)) begin
        failures++; $display("FAIL defaults_armed bit=%0d actual=%b expected=%b", i+1, armed, (i >= 3));
      end
    end
    checks++;
    if (match_count !== 8'd2) begin
      failures++; $display("FAIL defaults_count actual=%0d expected=2", match_count);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s1;
    logic [6:0] e1;
    logic [7:0] s2;
    logic [7:0] e2;
    s1 = 7'b0110110;
    e1 = 7'b0001000;
    s2 = 8'b01100110;
    e2 = 8'b00010001;
    load_cfg(8'h06, 8'hFF, 4'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s1[6-i]);
      checks++;
      if (out !== e1[6-i]) begin
        failures++; $display("FAIL nonovl_a_out bit=%0d actual=%b expected=%b", i+1, out, e1[6-i]);
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      failures++; $display("FAIL nonovl_a_count actual=%0d expected=1", match_count);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s2[7-i]);
      checks++;
      if (out !== e2[7-i]) begin
        failures++; $display("FAIL nonovl_b_out bit=%0d actual=%b expected=%b", i+1, out, e2[7-i]);
      end
    end
    checks++;
    if (match_count !== 8'd3) begin
      failures++; $display("FAIL nonovl_b_count actual=%0d expected=3", match_count);
    end
  endtask

  // len 3, pattern 101, mask 101: 101 and 111 match, 100 does not.
  task automatic test_mask();
    logic [2:0] streams [3];
    logic       exp_hit [3];
    streams[0] = 3'b101; exp_hit[0] = 1'b1;
    streams[1] = 3'b111; exp_hit[1] = 1'b1;
    streams[2] = 3'b100; exp_hit[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_cfg(8'h05, 8'h05, 4'd3, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, streams[k][2-i]);
        checks++;
        if (out !== ((i == 2) ? exp_hit[k] : 1'b0)) begin
          failures++; $display("FAIL mask_out stream=%0d bit=%0d actual=%b expected=%b",
                               k, i+1, out, (i == 2) ? exp_hit[k] : 1'b0);
        end
      end
    end
  endtask

  task automatic test_valid_gaps();
    logic [3:0] s;
    s = 4'b0110;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s[3-i]);
      checks++;
      if (out !== (i == 3)) begin
        failures++; $display("FAIL gaps_out bit=%0d actual=%b expected=%b", i+1, out, (i == 3));
      end
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          drive(1'b0, ~s[3-i]);
          checks++;
          if (out !== 1'b0) begin
            failures++; $display("FAIL gaps_idle_out bit=%0d gap=%0d actual=%b expected=0", i+1, g, out);
          end
        end
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      failures++; $display("FAIL gaps_count actual=%0d expected=1", match_count);
    end
    // cfg_load with a concurrent valid bit: bit dropped; len 0 acts as 1.
    load_cfg(8'h01, 8'hFF, 4'd0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (out !== 1'b0 || armed !== 1'b0 || match_count !== 8'd0) begin
      failures++; $display("FAIL load_conflict out/armed/count actual=%b/%b/%0d expected=0/0/0",
                           out, armed, match_count);
    end
    drive(1'b1, 1'b1);
    checks++;
    if (out !== 1'b1 || armed !== 1'b1 || match_count !== 8'd1) begin
      failures++; $display("FAIL len0_match out/armed/count actual=%b/%b/%0d expected=1/1/1",
                           out, armed, match_count);
    end
  endtask

  task automatic test_saturation();
    load_cfg(8'h01, 8'hFF, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b1);
      checks++;
      if (out3 !== 1'b1 || armed3 !== 1'b1) begin
        failures++; $display("FAIL sat_out match=%0d out/armed actual=%b/%b expected=1/1", i, out3, armed3);
      end
      checks++;
      if (match_count3 !== 3'((i < 7) ? i : 7)) begin
        failures++; $display("FAIL sat_count match=%0d actual=%0d expected=%0d", i, match_count3, (i < 7) ? i : 7);
      end
      checks++;
      if (count_sat3 !== (i >= 7)) begin
        failures++; $display("FAIL sat_flag match=%0d actual=%b expected=%b", i, count_sat3, (i >= 7));
      end
    end
    checks++;
    if (match_count !== 8'd9 || count_sat !== 1'b0) begin
      failures++; $display("FAIL sat_wide count/sat actual=%0d/%b expected=9/0", match_count, count_sat);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] c;
    a = 3'b011;
    b = 3'b110;
    c = 4'b0110;
    load_cfg(8'h03, 8'hFF, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, a[2-i]);
      checks++;
      if (out !== (i == 2)) begin
        failures++; $display("FAIL rmid_pre_out bit=%0d actual=%b expected=%b", i+1, out, (i == 2));
      end
    end
    reset = 1'b1;
    data_valid = 1'b1;
    data_stream = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    data_valid = 1'b0;
    checks++;
    if (out !== 1'b0 || match_count !== 8'd0 || count_sat !== 1'b0 || armed !== 1'b0) begin
      failures++; $display("FAIL rmid_reset out/count/sat/armed actual=%b/%0d/%b/%b expected=0/0/0/0",
                           out, match_count, count_sat, armed);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, b[2-i]);
      checks++;
      if (out !== 1'b0) begin
        failures++; $display("FAIL rmid_b_out bit=%0d actual=%b expected=0", i+1, out);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, c[3-i]);
      checks++;
      if (out !== (i == 3)) begin
        failures++; $display("FAIL rmid_c_out bit=%0d actual=%b expected=%b", i+1, out, (i == 3));
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      failures++; $display("FAIL rmid_count actual=%0d expected=1", match_count);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    data_valid  = 1'b0;
    data_stream = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h00;
    cfg_mask    = 8'hFF;
    cfg_len     = 4'd4;
    cfg_overlap = 1'b1;

    test_reset();
    test_defaults();
    test_nonoverlap();
    test_mask();
    test_valid_gaps();
    test_saturation();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Runtime-programmable serial sequence detector. Successor to the fixed-pattern detector.
- Pattern, length (1..N_MAX), don't-care mask and overlap mode are loaded at run time, with no re-synthesis.
- Input bits are qualified by a valid strobe. A saturating match counter is provided.
- Sits on a serial bit stream (e.g. deserialiser output) and flags frame/sync words to downstream control logic.

Parameters:
- N_MAX, 8, maximum pattern length in bits (>=2).
- CW, 8, match_count width.
- DEFAULT_LEN, 4, active length after reset (1..N_MAX).
- DEFAULT_PATTERN, 8'b0000_0110, active pattern after reset. LSB = newest bit.
- Derived: LW = $clog2(N_MAX+1), the width of cfg_len.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_valid  in  1  data_stream is sampled only when high.
- data_stream  in  1  serial input bit.
- cfg_load  in  1  one-cycle strobe; latches the cfg_* inputs into the active config.
- cfg_pattern  in  N_MAX  pattern; bit 0 = most recent bit.
- cfg_mask  in  N_MAX  1 = compare this bit, 0 = don't care.
- cfg_len  in  LW  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- out  out  1  match pulse.
- match_count  out  CW  number of matches, saturating.
- count_sat  out  1  sticky flag: counter has saturated.
- armed  out  1  high when fill >= active length, so the next valid bit can produce a match.

Behaviour:
- Reset (synchronous, highest priority). Applies:
  - shift=0, fill=0, out=0, match_count=0, count_sat=0, armed=0.
  - Active pattern=DEFAULT_PATTERN, mask=all ones, len=DEFAULT_LEN, overlap=1.
- cfg_load (priority below reset, above data). Applies:
  - Latch pattern, mask, len, overlap.
  - Clear shift, fill, out, match_count, count_sat.
  - Any data bit presented in the same cycle is discarded.
- Length rules: cfg_len=0 is treated as 1; cfg_len>N_MAX is clamped to N_MAX. Clamping is applied at latch time.
- Accepted bit (data_valid=1):
  - shift_next = {shift[N_MAX-2:0], data_stream}.
  - fill increments, saturating at N_MAX.
- Match condition, evaluated on the accepted bit:
  - (fill+1) >= len, and
  - ((shift_next ^ pattern) & mask & lenmask) == 0, where lenmask has the low len bits set.
  - The compare uses shift_next, not shift, so there is no extra cycle of lag.
- Latency: out is registered and goes high on the same clock edge that samples the final matching bit. It is high for exactly one cycle per match.
- out is 0 in any cycle where data_valid=0 or no match occurs. It never holds across cycles.
- Non-overlap mode: on a match, fill resets to 0, so the next match needs len fresh bits. The shift contents are kept but are unused until refilled.
- Overlap mode: fill is unaffected by a match.
- match_count increments on each match. At all-ones it holds, and count_sat is set and stays set until reset or cfg_load.
- armed = (fill >= len), registered.
- data_valid=0: shift, fill and match_count hold; out=0.
- Reset mid-stream discards all partial fill. The first match after reset needs len new accepted bits.

Test Plan:
1. Defaults (N_MAX=8, len 4, pattern 0110, overlap): after reset, stream 0,1,1,0,1,1,0 with data_valid=1 -> out pulses on bits 4 and 7; match_count=2; armed=1 from bit 4 onward.
2. cfg_load with pattern 0110, len 4, mask 1111, overlap=0:
   - stream 0,1,1,0,1,1,0 -> single pulse on bit 4; match_count=1.
   - then stream 0,1,1,0,0,1,1,0 -> pulses on bits 4 and 8 of that stream.
3. Mask: load len 3, pattern 3'b101, mask 3'b101 -> streams 1,0,1 and 1,1,1 each pulse on bit 3; 1,0,0 gives no pulse.
4. Valid gaps and conflicts:
   - Defaults, stream 0,1,1,0 with data_valid=0 for 2 cycles between each bit -> one pulse on the cycle bit 4 is accepted; out=0 during every gap cycle.
   - cfg_load asserted in the same cycle as a valid bit -> that bit is ignored (fill stays 0).
5. Saturation, CW=3: 9 overlapping matches of len 1, pattern 1 (nine valid 1s) -> match_count stops at 7; count_sat=1 from the 7th match on; out still pulses on all 9.
6. Reset mid-operation:
   - Load len 2, pattern 11, then feed 0,1,1 (match on bit 3).
   - Assert reset for 1 cycle -> all outputs 0 and config back to defaults.
   - Feed 1,1,0 -> no pulse. Feed a further 0,1,1,0 -> pulse on the last bit.
